d5m_frame_tx: RTL and testbench

D5M_FRAME_TX -- requirements
Module: d5m_frame_tx

---
 rtl/generic_pack.sv | 30 +++
 rtl/d5m_frame_tx_if.sv | 12 +
 rtl/d5m_frame_tx_pattern_gen.sv | 29 ++
 rtl/d5m_frame_tx.sv | 184 ++++++++++++++++++
 tb/tb_d5m_frame_tx.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/generic_pack.sv
// Shared types and constants for the D5M frame transmitter: FSM states,
// pixel pattern selectors and the Bayer colour codes.
package generic_pack;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FV_LEAD  = 3'd1,
    ST_LINE     = 3'd2,
    ST_HBLANK   = 3'd3,
    ST_FV_TRAIL = 3'd4,
    ST_VBLANK   = 3'd5
  } frame_state_t;

  typedef enum logic [1:0] {
    PAT_GRADIENT = 2'd0,
    PAT_BAYER    = 2'd1,
    PAT_FRAME_ID = 2'd2,
    PAT_BLACK    = 2'd3
  } pattern_t;

  localparam logic [11:0] BAYER_R = 12'hF00;
  localparam logic [11:0] BAYER_G = 12'h0F0;
  localparam logic [11:0] BAYER_B = 12'h00F;

  // Frame-valid is asserted from the lead-in through the trailer.
  function automatic logic frame_active(input frame_state_t s);
    return (s == ST_FV_LEAD) || (s == ST_LINE) || (s == ST_HBLANK) || (s == ST_FV_TRAIL);
  endfunction

endpackage

// File: rtl/d5m_frame_tx_if.sv
// D5M video bus: frame-valid, line-valid and pixel data, one pixel per pixclk.
// Free-running source, no backpressure path.
interface d5m_frame_tx_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  ifval;
  logic                  ilval;
  logic [DATA_WIDTH-1:0] idata;

  modport master (output ifval, ilval, idata);
  modport slave  (input  ifval, ilval, idata);
endinterface

// File: rtl/d5m_frame_tx_pattern_gen.sv
// Combinational test-pattern pixel for a given column/row/frame; the parent registers it.
// Zero latency, no backpressure.
module d5m_pattern_gen
  import generic_pack::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic [15:0]           col,
  input  logic [15:0]           row,
  input  logic [15:0]           frame,
  input  pattern_t              pattern,
  output logic [DATA_WIDTH-1:0] pixel
);

  always_comb begin
    pixel = '0;
    unique case (pattern)
      PAT_GRADIENT: pixel = DATA_WIDTH'(32'(col) + 32'(row));
      PAT_BAYER: begin
        // RGGB tiling: even rows alternate R/G, odd rows alternate G/B.
        if (!row[0]) pixel = col[0] ? DATA_WIDTH'(BAYER_G) : DATA_WIDTH'(BAYER_R);
        else         pixel = col[0] ? DATA_WIDTH'(BAYER_B) : DATA_WIDTH'(BAYER_G);
      end
      PAT_FRAME_ID: pixel = DATA_WIDTH'(frame);
      default:      pixel = '0;
    endcase
  end

endmodule

// File: rtl/d5m_frame_tx.sv
// Generates D5M-style frames (ifval/ilval/idata) with programmable blanking and test patterns.
// All outputs registered one cycle behind the FSM; free-running source, no backpressure.
module d5m_frame_tx
  import generic_pack::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int H_BLANK    = 16,
  parameter int FV_LEAD    = 4,
  parameter int FV_TRAIL   = 4,
  parameter int V_BLANK    = 32
) (
  input  logic                  pixclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [1:0]            pattern_sel,
  d5m_frame_tx_if.master        vid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam logic [15:0] COL_LAST   = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_LAST   = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] HB_LAST    = 16'(H_BLANK - 1);
  localparam logic [15:0] LEAD_LAST  = 16'(FV_LEAD - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(FV_TRAIL - 1);
  localparam logic [15:0] VB_LAST    = 16'(V_BLANK - 1);

  frame_state_t state, state_nxt;
  logic [15:0]  col, col_nxt;
  logic [15:0]  row, row_nxt;
  logic [15:0]  cnt, cnt_nxt;
  pattern_t     pat_q, pat_nxt;
  logic         cont_q, cont_nxt;

  logic         frame_begin;
  logic         lines_done;
  logic         trail_done;
  logic         frame_end;
  logic [DATA_WIDTH-1:0] pixel;

  d5m_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern_gen (
    .col     (col),
    .row     (row),
    .frame   (frame_count),
    .pattern (pat_q),
    .pixel   (pixel)
  );

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state  <= ST_IDLE;
      col    <= '0;
      row    <= '0;
      cnt    <= '0;
      pat_q  <= PAT_GRADIENT;
      cont_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      col    <= col_nxt;
      row    <= row_nxt;
      cnt    <= cnt_nxt;
      pat_q  <= pat_nxt;
      cont_q <= cont_nxt;
    end
  end

  // Zero-length blanking phases fall through to the following phase in the
  // same cycle, so the events below are chained rather than exclusive.
  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    row_nxt     = row;
    cnt_nxt     = cnt;
    pat_nxt     = pat_q;
    cont_nxt    = cont_q;
    frame_begin = 1'b0;
    lines_done  = 1'b0;
    trail_done  = 1'b0;
    frame_end   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) frame_begin = 1'b1;
      end
      ST_FV_LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_nxt = ST_LINE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_LINE: begin
        if (col == COL_LAST) begin
          col_nxt = '0;
          if (row == ROW_LAST) begin
            lines_done = 1'b1;
          end else begin
            row_nxt = row + 16'd1;
            cnt_nxt = '0;
            if (H_BLANK > 0) state_nxt = ST_HBLANK;
          end
        end else begin
          col_nxt = col + 16'd1;
        end
      end
      ST_HBLANK: begin
        if (cnt == HB_LAST) begin
          state_nxt = ST_LINE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_FV_TRAIL: begin
        if (cnt == TRAIL_LAST) trail_done = 1'b1;
        else                   cnt_nxt = cnt + 16'd1;
      end
      ST_VBLANK: begin
        if (cnt == VB_LAST) frame_end = 1'b1;
        else                cnt_nxt = cnt + 16'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (lines_done) begin
      if (FV_TRAIL > 0) begin
        state_nxt = ST_FV_TRAIL;
        cnt_nxt   = '0;
      end else begin
        trail_done = 1'b1;
      end
    end

    if (trail_done) begin
      if (V_BLANK > 0) begin
        state_nxt = ST_VBLANK;
        cnt_nxt   = '0;
      end else begin
        frame_end = 1'b1;
      end
    end

    if (frame_end) begin
      state_nxt = ST_IDLE;
      if (cont_q) frame_begin = 1'b1;
    end

    // Pattern and loop mode are frozen for the whole frame once it begins.
    if (frame_begin) begin
      state_nxt = (FV_LEAD > 0) ? ST_FV_LEAD : ST_LINE;
      col_nxt   = '0;
      row_nxt   = '0;
      cnt_nxt   = '0;
      pat_nxt   = pattern_t'(pattern_sel);
      cont_nxt  = continuous;
    end
  end

  always_ff @(posedge pixclk) begin
    if (reset) begin
      vid.ifval   <= 1'b0;
      vid.ilval   <= 1'b0;
      vid.idata   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      vid.ifval   <= frame_active(state);
      vid.ilval   <= (state == ST_LINE);
      vid.idata   <= (state == ST_LINE) ? pixel : '0;
      busy        <= (state != ST_IDLE);
      frame_done  <= frame_end;
      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_d5m_frame_tx.sv
// Directed bench for d5m_frame_tx: a timeline model predicts every output cycle,
// plus literal expectations for the pixel sequences and frame timing.
module tb_d5m_frame_tx;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int HB   = 3;
  localparam int FL   = 2;
  localparam int FT   = 2;
  localparam int VB   = 5;
  localparam int FLEN = FL + W * H + HB * (H - 1) + FT + VB;

  typedef struct packed {
    logic        ifval;
    logic        ilval;
    logic [11:0] idata;
    logic        busy;
    logic        fdone;
    logic [15:0] fc;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, continuous;
  logic [1:0]  pattern_sel;
  logic        busy, frame_done;
  logic [15:0] frame_count;
  logic        start_b;
  logic        busy_b, frame_done_b;
  logic [15:0] frame_count_b;

  d5m_frame_tx_if #(.DATA_WIDTH(12)) vid ();
  d5m_frame_tx_if #(.DATA_WIDTH(12)) vid_b ();

  d5m_frame_tx #(
    .DATA_WIDTH(12), .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB),
    .FV_LEAD(FL), .FV_TRAIL(FT), .V_BLANK(VB)
  ) dut (
    .pixclk(clk), .reset(reset), .start(start), .continuous(continuous),
    .pattern_sel(pattern_sel), .vid(vid), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  d5m_frame_tx #(
    .DATA_WIDTH(12), .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(0),
    .FV_LEAD(FL), .FV_TRAIL(FT), .V_BLANK(VB)
  ) dut_hb0 (
    .pixclk(clk), .reset(reset), .start(start_b), .continuous(1'b0),
    .pattern_sel(2'd0), .vid(vid_b), .busy(busy_b),
    .frame_done(frame_done_b), .frame_count(frame_count_b)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  int   push_fc = 0;
  int   last_fc = 0;

  // monitor state
  int cyc = 0;
  int ifv_hi, last_ifv, fd_cyc, fd_cnt, chain, il_rises;
  int run_b, max_run_b;
  int pix_q[$];
  int pix_b[$];
  logic prev_fd = 1'b0, prev_il = 1'b0;

  int exp_grad[8]  = '{0, 1, 2, 3, 1, 2, 3, 4};
  int exp_bayer[8] = '{'hF00, 'h0F0, 'hF00, 'h0F0, 'h0F0, 'h00F, 'h0F0, 'h00F};

  function automatic int model_pix(input int pat, input int c, input int r, input int fc);
    case (pat)
      0: return (c + r) % 4096;
      1: if (r % 2 == 0) return (c % 2 == 0) ? 'hF00 : 'h0F0;
         else            return (c % 2 == 0) ? 'h0F0 : 'h00F;
      2: return fc % 4096;
      default: return 0;
    endcase
  endfunction

  task automatic push(input bit fv, input bit lv, input int d, input bit b, input bit fd, input int fc);
    obs_t e;
    e.ifval = fv; e.ilval = lv; e.idata = 12'(d);
    e.busy = b; e.fdone = fd; e.fc = 16'(fc);
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    push(0, 0, 0, 0, 0, push_fc);
  endtask

  // One frame as a flat timeline: lead-in, lines with blanking between, trailer, vertical blank.
  task automatic push_frame(input int pat);
    int fc = push_fc;
    for (int i = 0; i < FL; i++) push(1, 0, 0, 1, 0, fc);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) push(1, 1, model_pix(pat, c, r, fc), 1, 0, fc);
      if (r < H - 1) for (int i = 0; i < HB; i++) push(1, 0, 0, 1, 0, fc);
    end
    for (int i = 0; i < FT; i++) push(1, 0, 0, 1, 0, fc);
    for (int i = 0; i < VB - 1; i++) push(0, 0, 0, 1, 0, fc);
    push(0, 0, 0, 1, 1, (fc + 1) % 65536);
    push_fc = (fc + 1) % 65536;
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    cyc++;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e = '0;
      e.fc = 16'(last_fc);
    end
    last_fc = int'(e.fc);
    a.ifval = vid.ifval; a.ilval = vid.ilval; a.idata = vid.idata;
    a.busy = busy; a.fdone = frame_done; a.fc = frame_count;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL stream cycle %0d: got ifval=%b ilval=%b idata=%h busy=%b frame_done=%b frame_count=%0d, expected ifval=%b ilval=%b idata=%h busy=%b frame_done=%b frame_count=%0d",
               cyc, a.ifval, a.ilval, a.idata, a.busy, a.fdone, a.fc,
               e.ifval, e.ilval, e.idata, e.busy, e.fdone, e.fc);
    end
    if (vid.ifval === 1'b1) begin ifv_hi++; last_ifv = cyc; end
    if (vid.ilval === 1'b1) pix_q.push_back(int'(vid.idata));
    if (vid.ilval === 1'b1 && !prev_il) il_rises++;
    if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
    if (prev_fd && vid.ifval === 1'b1) chain++;
    prev_fd = (frame_done === 1'b1);
    prev_il = (vid.ilval === 1'b1);
    if (vid_b.ilval === 1'b1) begin
      run_b++;
      pix_b.push_back(int'(vid_b.idata));
      if (run_b > max_run_b) max_run_b = run_b;
    end else run_b = 0;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_seq(input string name, input int got[$], input int exp[8]);
    check({name, " length"}, got.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s pixel %0d", name, i), (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic clear_mon();
    ifv_hi = 0; last_ifv = 0; fd_cyc = 0; fd_cnt = 0; chain = 0; il_rises = 0;
    run_b = 0; max_run_b = 0;
    pix_q.delete();
    pix_b.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin step(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d expected cycles still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    push_fc = 0;
    last_fc = 0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic pulse_start(input int pat);
    pattern_sel = 2'(pat);
    continuous  = 1'b0;
    start       = 1'b1;
    if (exp_q.size() == 0) begin
      push_idle();
      push_frame(pat);
    end
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; pattern_sel = 2'd0; start_b = 1'b0;
    repeat (3) step();
    check("reset busy", int'(busy), 0);
    check("reset frame_count", int'(frame_count), 0);
    check("reset ifval", int'(vid.ifval), 0);
    reset = 1'b0;
    step();

    // single frame, gradient
    clear_mon();
    pulse_start(0);
    wait_idle("gradient frame");
    check("gradient ifval high cycles", ifv_hi, 15);
    check_seq("gradient", pix_q, exp_grad);
    check("frame_done after ifval falls", fd_cyc - last_ifv, 5);
    check("gradient frame_count", int'(frame_count), 1);

    // single frame, Bayer
    clear_mon();
    pulse_start(1);
    wait_idle("bayer frame");
    check_seq("bayer", pix_q, exp_bayer);
    check("bayer frame_count", int'(frame_count), 2);

    // three looping frames of the frame-id pattern
    do_reset();
    clear_mon();
    pattern_sel = 2'd2; continuous = 1'b1; start = 1'b1;
    push_idle();
    repeat (3) push_frame(2);
    step();
    start = 1'b0;
    n = 0;
    while (exp_q.size() > 2 * FLEN - 3 && n < 200) begin step(); n++; end
    continuous = 1'b0;
    wait_idle("continuous frames");
    check("continuous pixel count", pix_q.size(), 24);
    check("frame 0 id", (pix_q.size() > 0) ? pix_q[0] : -1, 0);
    check("frame 1 id", (pix_q.size() > 8) ? pix_q[8] : -1, 1);
    check("frame 2 id", (pix_q.size() > 16) ? pix_q[16] : -1, 2);
    check("ifval right after frame_done", chain, 2);
    check("continuous frame_done count", fd_cnt, 3);
    check("continuous frame_count", int'(frame_count), 3);

    // start and pattern change mid-frame are ignored
    clear_mon();
    pulse_start(0);
    repeat (5) step();
    pulse_start(1);
    wait_idle("mid-frame start");
    repeat (25) step();
    check_seq("mid-frame pattern held", pix_q, exp_grad);
    check("mid-frame frame_done count", fd_cnt, 1);
    check("mid-frame busy after", int'(busy), 0);
    pattern_sel = 2'd0;

    // reset during the second line, then start on the first cycle out of reset
    clear_mon();
    pulse_start(0);
    n = 0;
    while (il_rises < 2 && n < 100) begin step(); n++; end
    check("second line reached", int'(il_rises >= 2), 1);
    reset = 1'b1;
    exp_q.delete();
    push_fc = 0;
    last_fc = 0;
    step();
    check("reset mid-frame ifval", int'(vid.ifval), 0);
    check("reset mid-frame ilval", int'(vid.ilval), 0);
    check("reset mid-frame busy", int'(busy), 0);
    check("reset mid-frame frame_count", int'(frame_count), 0);
    step();
    reset = 1'b0; start = 1'b1; pattern_sel = 2'd0;
    push_idle();
    push_frame(0);
    clear_mon();
    step();
    start = 1'b0;
    wait_idle("start after reset");
    check_seq("start after reset", pix_q, exp_grad);
    check("start after reset frame_count", int'(frame_count), 1);

    // zero horizontal blanking: lines run back to back
    clear_mon();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    repeat (30) step();
    check("no hblank ilval run", max_run_b, 8);
    check_seq("no hblank", pix_b, exp_grad);
    check("no hblank frame_count", int'(frame_count_b), 1);
    check("no hblank busy after", int'(busy_b), 0);
    check("no hblank frame_done idle", int'(frame_done_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
